pc_flag_ctrl: RTL

Sequential control stage that closes the loop around the execute stage. Holds the architectural PC and the Z/V/N flag register, and selects the next PC from the execute stage's pc_branch. Owns the run/halt state machine and a retired-instruction counter. Drives the PC to instruction fetch and the stored flags back to execute for branch evaluation.

---
 rtl/pc_flag_ctrl_pkg.sv | 37 +++
 rtl/pc_flag_ctrl_if.sv | 31 +++
 rtl/pc_flag_ctrl_flag_reg.sv | 41 ++++
 rtl/pc_flag_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pc_flag_ctrl_pkg.sv
// Shared definitions for the PC / flag control stage: opcode constants,
// run-state encoding and the opcode-to-flag-update classification.
package pc_flag_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  // Which flag groups a retiring opcode is allowed to overwrite.
  typedef struct packed {
    logic we_z;
    logic we_vn;
  } flag_we_t;

  // Arithmetic ops own all three flags; logic/shift ops only report zero.
  function automatic flag_we_t flag_class(input logic [3:0] op);
    flag_we_t cls;
    cls = '{we_z: 1'b0, we_vn: 1'b0};
    case (op)
      OP_ADD, OP_SUB:                 cls = '{we_z: 1'b1, we_vn: 1'b1};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = '{we_z: 1'b1, we_vn: 1'b0};
      default:                        cls = '{we_z: 1'b0, we_vn: 1'b0};
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/pc_flag_ctrl_if.sv
// Bundle of the execute/fetch-facing signals of the PC / flag control stage.
// The master side is whoever drives the instruction stream (execute/bench);
// the slave side is the control stage itself.
interface pc_flag_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              instr_valid;
  logic [3:0]        ALU_operation;
  logic [15:0]       pc_branch;
  logic              Z_in;
  logic              V_in;
  logic              N_in;
  logic [15:0]       pc;
  logic [15:0]       pc_inc_2;
  logic              flag_Z;
  logic              flag_V;
  logic              flag_N;
  logic              halted;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output instr_valid, ALU_operation, pc_branch, Z_in, V_in, N_in,
    input  pc, pc_inc_2, flag_Z, flag_V, flag_N, halted, retire_cnt
  );

  modport slave (
    input  instr_valid, ALU_operation, pc_branch, Z_in, V_in, N_in,
    output pc, pc_inc_2, flag_Z, flag_V, flag_N, halted, retire_cnt
  );

endinterface

// File: rtl/pc_flag_ctrl_flag_reg.sv
// Z/V/N flag register with separate write enables for the zero flag and the
// overflow/negative pair, so logic ops can refresh Z without disturbing V/N.
module pc_flag_ctrl_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic we_z,
  input  logic we_vn,
  input  logic z_in,
  input  logic v_in,
  input  logic n_in,
  output logic flag_z,
  output logic flag_v,
  output logic flag_n
);

  logic z_r;
  logic v_r;
  logic n_r;

  // Flag storage: cleared on reset, each group loaded only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_r <= 1'b0;
      v_r <= 1'b0;
      n_r <= 1'b0;
    end else begin
      if (we_z) begin
        z_r <= z_in;
      end
      if (we_vn) begin
        v_r <= v_in;
        n_r <= n_in;
      end
    end
  end

  assign flag_z = z_r;
  assign flag_v = v_r;
  assign flag_n = n_r;

endmodule

// File: rtl/pc_flag_ctrl.sv
// PC / flag control stage: holds the architectural PC and Z/V/N flags,
// sequences boot -> run -> halt, and counts retired instructions.
module pc_flag_ctrl
  import pc_flag_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,   // active-high despite the name
  pc_flag_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [15:0]      pc_r;
  logic [CNT_W-1:0] retire_cnt_r;
  logic             halted_r;
  logic             retire_s;
  logic             pc_load_s;
  logic             is_hlt_s;
  flag_we_t         cls_s;
  logic             we_z_s;
  logic             we_vn_s;

  assign is_hlt_s = (bus.ALU_operation == OP_HLT);
  assign cls_s    = flag_class(bus.ALU_operation);

  // Run-state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= S_BOOT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and retire/PC-load decode; HLT retires but keeps the PC on it.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    pc_load_s    = 1'b0;
    case (state_r)
      S_BOOT: begin
        next_state_s = S_RUN;
      end
      S_RUN: begin
        if (bus.instr_valid) begin
          retire_s = 1'b1;
          if (is_hlt_s) begin
            next_state_s = S_HALT;
          end else begin
            pc_load_s = 1'b1;
          end
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_HALT: begin
        next_state_s = S_HALT;
      end
      default: begin
        next_state_s = S_BOOT;
      end
    endcase
  end

  // Flag writes only happen on a retiring non-HLT instruction.
  always_comb begin
    we_z_s  = 1'b0;
    we_vn_s = 1'b0;
    if (pc_load_s) begin
      we_z_s  = cls_s.we_z;
      we_vn_s = cls_s.we_vn;
    end else begin
      we_z_s  = 1'b0;
      we_vn_s = 1'b0;
    end
  end

  // Program counter: takes the execute stage's target verbatim on retire.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_r <= RESET_PC;
    end else if (pc_load_s) begin
      pc_r <= bus.pc_branch;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      retire_cnt_r <= '0;
    end else if (retire_s && (retire_cnt_r != CNT_MAX)) begin
      retire_cnt_r <= retire_cnt_r + CNT_ONE;
    end
  end

  // Registered halt indicator, tracking the state we are about to enter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (next_state_s == S_HALT);
    end
  end

  pc_flag_ctrl_flag_reg u_flag_reg (
    .clk    (clk),
    .rst    (rst_n),
    .we_z   (we_z_s),
    .we_vn  (we_vn_s),
    .z_in   (bus.Z_in),
    .v_in   (bus.V_in),
    .n_in   (bus.N_in),
    .flag_z (bus.flag_Z),
    .flag_v (bus.flag_V),
    .flag_n (bus.flag_N)
  );

  assign bus.pc         = pc_r;
  assign bus.pc_inc_2   = pc_r + 16'd2;
  assign bus.halted     = halted_r;
  assign bus.retire_cnt = retire_cnt_r;

endmodule
